// File: rtl/mux_n_rr.sv
// rtl/mux_n_rr.sv - N-channel registered mux with manual or round-robin arbitration
// Optional transfer counter (xfer_cnt, cnt_clr) is enabled by defining MUX_N_RR_CNT_EN.
module mux_n_rr #(
  parameter int SIZE   = 64,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NUM_CH-1:0]      in_valid,
  input  logic [NUM_CH*SIZE-1:0] in_data,
  output logic [NUM_CH-1:0]      in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE-1:0]        data_o,
  output logic [SEL_W-1:0]       ch_o
`ifdef MUX_N_RR_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [15:0]            xfer_cnt
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load;
  logic             grant_ok;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;

  assign load = ~out_valid_q | out_ready;

  // Round-robin search starts one past the last granted channel and wraps.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      if (int'(sel) < NUM_CH) begin
        grant_ok  = in_valid[sel];
        grant_idx = sel;
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = SEL_W'((int'(last_q) + k) % NUM_CH);
        if (!grant_ok && in_valid[cand]) begin
          grant_ok  = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset_n && load && grant_ok) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    ch_d        = ch_q;
    last_d      = last_q;
    if (load) begin
      if (grant_ok) begin
        out_valid_d = 1'b1;
        data_d      = in_data[int'(grant_idx)*SIZE +: SIZE];
        ch_d        = grant_idx;
        last_d      = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ch_q        <= '0;
      last_q      <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign ch_o      = ch_q;

`ifdef MUX_N_RR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
// tb/tb_mux_n_rr.sv - directed self-checking bench for mux_n_rr
// Counter scenarios run only when MUX_N_RR_CNT_EN is defined.
module tb_mux_n_rr;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_o;
  logic [1:0]   ch_o;
`ifdef MUX_N_RR_CNT_EN
  logic         cnt_clr;
  logic [15:0]  xfer_cnt;
`endif

  logic [63:0] ch_data [4];
  int tests_run = 0;
  int failed    = 0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 4; i++) in_data[i*64 +: 64] = ch_data[i];
  end

  mux_n_rr #(.SIZE(64), .NUM_CH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .ch_o      (ch_o)
`ifdef MUX_N_RR_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic test_reset();
    reset_n  = 1'b0;
    mode     = 1'b1;
    sel      = 2'd0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
`ifdef MUX_N_RR_CNT_EN
    cnt_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) ch_data[i] = 64'hA0 + 64'(i);
    repeat (2) @(negedge clock);
    tests_run++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (data_o !== 64'h0) begin failed++; $display("FAIL reset_data_o: got %h want 0", data_o); end
    tests_run++; if (ch_o !== 2'd0) begin failed++; $display("FAIL reset_ch_o: got %0d want 0", ch_o); end
    tests_run++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_ch;
    reset_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 4'b0001) begin failed++; $display("FAIL rr_all_first_ready: got %b want 0001", in_ready); end
    for (int k = 0; k < 8; k++) begin
      exp_ch = 2'(k % 4);
      @(posedge clock);
      @(negedge clock);
      tests_run++; if (out_valid !== 1'b1) begin failed++; $display("FAIL rr_all_valid[%0d]: got %b want 1", k, out_valid); end
      tests_run++; if (ch_o !== exp_ch) begin failed++; $display("FAIL rr_all_ch[%0d]: got %0d want %0d", k, ch_o, exp_ch); end
      tests_run++; if (data_o !== 64'hA0 + 64'(exp_ch)) begin failed++; $display("FAIL rr_all_data[%0d]: got %h want %h", k, data_o, 64'hA0 + 64'(exp_ch)); end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch;
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      tests_run++; if (in_ready !== (4'b0001 << exp_ch)) begin failed++; $display("FAIL rr_sparse_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << exp_ch); end
      @(posedge clock);
      @(negedge clock);
      tests_run++; if (ch_o !== exp_ch) begin failed++; $display("FAIL rr_sparse_ch[%0d]: got %0d want %0d", k, ch_o, exp_ch); end
    end
  endtask

  task automatic test_stall();
    mode       = 1'b0;
    sel        = 2'd2;
    in_valid   = 4'b0100;
    ch_data[2] = 64'hB2;
    #1;
    tests_run++; if (in_ready !== 4'b0100) begin failed++; $display("FAIL stall_first_ready: got %b want 0100", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (data_o !== 64'hB2) begin failed++; $display("FAIL stall_first_data: got %h want b2", data_o); end
    out_ready  = 1'b0;
    ch_data[2] = 64'hC2;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, in_ready); end
      @(posedge clock);
      @(negedge clock);
      tests_run++; if (data_o !== 64'hB2 || out_valid !== 1'b1 || ch_o !== 2'd2) begin
        failed++; $display("FAIL stall_hold[%0d]: got data %h valid %b ch %0d want data b2 valid 1 ch 2", k, data_o, out_valid, ch_o);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 4'b0100) begin failed++; $display("FAIL stall_release_ready: got %b want 0100", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (data_o !== 64'hC2 || out_valid !== 1'b1) begin
      failed++; $display("FAIL stall_no_bubble: got data %h valid %b want data c2 valid 1", data_o, out_valid);
    end
  endtask

  task automatic test_manual_nogrant();
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    tests_run++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL nogrant_ready: got %b want 0000", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (out_valid !== 1'b0) begin failed++; $display("FAIL nogrant_valid: got %b want 0", out_valid); end
    tests_run++; if (data_o !== 64'hC2 || ch_o !== 2'd2) begin failed++; $display("FAIL nogrant_hold: got data %h ch %0d want data c2 ch 2", data_o, ch_o); end
    sel = 2'd3;
    #1;
    tests_run++; if (in_ready !== 4'b1000) begin failed++; $display("FAIL sel3_ready: got %b want 1000", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (out_valid !== 1'b1 || ch_o !== 2'd3 || data_o !== 64'hA3) begin
      failed++; $display("FAIL sel3_load: got valid %b ch %0d data %h want valid 1 ch 3 data a3", out_valid, ch_o, data_o);
    end
  endtask

  task automatic test_reset_mid();
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    tests_run++; if (in_ready !== 4'b0001) begin failed++; $display("FAIL mid_pre_ready: got %b want 0001", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (ch_o !== 2'd0 || out_valid !== 1'b1) begin failed++; $display("FAIL mid_pre_load: got ch %0d valid %b want ch 0 valid 1", ch_o, out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || data_o !== 64'h0 || ch_o !== 2'd0) begin
      failed++; $display("FAIL mid_reset_outputs: got valid %b data %h ch %0d want 0 0 0", out_valid, data_o, ch_o);
    end
    tests_run++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL mid_reset_ready: got %b want 0000", in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 4'b0001) begin failed++; $display("FAIL mid_restart_ready: got %b want 0001", in_ready); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (ch_o !== 2'd0 || data_o !== 64'hA0 || out_valid !== 1'b1) begin
      failed++; $display("FAIL mid_restart_load: got ch %0d data %h valid %b want ch 0 data a0 valid 1", ch_o, data_o, out_valid);
    end
  endtask

`ifdef MUX_N_RR_CNT_EN
  task automatic test_counter();
    @(negedge clock);
    reset_n   = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #1;
    tests_run++; if (xfer_cnt !== 16'd0) begin failed++; $display("FAIL cnt_reset: got %0d want 0", xfer_cnt); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    tests_run++; if (xfer_cnt !== 16'd5) begin failed++; $display("FAIL cnt_five: got %0d want 5", xfer_cnt); end
    cnt_clr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cnt_clr = 1'b0;
    tests_run++; if (xfer_cnt !== 16'd0) begin failed++; $display("FAIL cnt_clear_priority: got %0d want 0", xfer_cnt); end
    repeat (65535) @(posedge clock);
    @(negedge clock);
    tests_run++; if (xfer_cnt !== 16'hFFFF) begin failed++; $display("FAIL cnt_full: got %h want ffff", xfer_cnt); end
    @(posedge clock);
    @(negedge clock);
    tests_run++; if (xfer_cnt !== 16'd0) begin failed++; $display("FAIL cnt_wrap: got %h want 0", xfer_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_manual_nogrant();
    test_reset_mid();
`ifdef MUX_N_RR_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mux_n_rr.md
Name: mux_n_rr

Overview:
- Parametrised N-channel, SIZE-bit multiplexer with a registered output and valid/ready handshaking on every input channel and on the output.
- Two selection modes:
  - Manual: an explicit selector picks the channel.
  - Round-robin: fair arbitration among the valid channels.
- Sits between producer blocks and a single shared consumer, such as a display/bus path. Successor to the fixed 4-input combinational mux.

Parameters:
- SIZE, 64, data width of each channel in bits (≥1)
- NUM_CH, 4, number of input channels (≥2)
- SEL_W, $clog2(NUM_CH), selector/grant index width; derived, do not override

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- mode  in  1  0 = manual select, 1 = round-robin
- sel  in  SEL_W  channel index used in manual mode
- in_valid  in  NUM_CH  per-channel valid; bit i belongs to channel i
- in_data  in  NUM_CH*SIZE  packed data; channel i occupies bits [i*SIZE +: SIZE]
- in_ready  out  NUM_CH  per-channel ready, combinational, at most one bit high
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts the word this cycle
- data_o  out  SIZE  registered output data
- ch_o  out  SEL_W  index of the channel that supplied data_o

Behaviour:
- Reset (async assert, sync-release safe):
  - out_valid=0, data_o=0, ch_o=0
  - last_grant=NUM_CH-1, so the first round-robin search starts at channel 0
  - in_ready is 0 while reset_n=0
- Output register is a single stage.
  - load = ~out_valid | out_ready.
  - Full throughput: one transfer per cycle when the consumer is always ready.
- Arbitration (combinational, evaluated each cycle):
  - Manual mode: candidate = sel. Grant only if sel < NUM_CH and in_valid[sel]=1. sel ≥ NUM_CH → no grant.
  - Round-robin mode: grant the first channel with in_valid=1, searching last_grant+1, last_grant+2, … with wrap at NUM_CH-1 → 0. No valid channel → no grant.
- in_ready[g] = load & grant_exists; all other bits are 0. Never depends on in_valid of another channel except through the grant.
- Transfer on channel g: in_valid[g] & in_ready[g]. At the next edge:
  - data_o ← in_data[g], ch_o ← g, out_valid ← 1
  - last_grant ← g, in both modes
- load=1 and no grant:
  - out_valid ← 0; data_o and ch_o hold their last values.
  - last_grant unchanged.
- out_valid=1 & out_ready=0 (stall):
  - data_o, ch_o and out_valid hold.
  - All in_ready=0; last_grant unchanged.
- Simultaneous output accept and new grant in the same cycle: the new word replaces the old one with no bubble.
- mode or sel change takes effect on the next arbitration only; a word already held in the output register is unaffected.
- Latency: 1 cycle from input transfer to out_valid.
- Reset mid-operation: any held word is discarded immediately, outputs take their reset values, and arbitration restarts from channel 0.
- No combinational path from in_data to data_o. The only combinational paths are out_ready/in_valid/mode/sel → in_ready.

Optional Feature:
- Macro MUX_N_RR_CNT_EN.
- Defined:
  - Adds output xfer_cnt (16 bits): count of output transfers (out_valid & out_ready).
  - Reset value 0; wraps 0xFFFF → 0.
  - Adds input cnt_clr (1 bit): synchronous clear to 0, taking priority over increment in the same cycle.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, mode=1, out_ready=1; in_valid=4'b1111, in_data ch i = 64'hA0+i, held 8 cycles → ch_o sequence 0,1,2,3,0,1,2,3; data_o sequence 64'hA0…A3 repeating; out_valid=1 from cycle 2.
- mode=1, in_valid=4'b1010, out_ready=1 → grants alternate 1,3,1,3; in_ready never set on channels 0 or 2.
- mode=0, sel=2, in_valid=4'b0100, out_ready=0 held 3 cycles after the first load → data_o frozen at ch2 word, in_ready=0 during the stall; on out_ready=1, the next word loads the same cycle with no bubble.
- mode=0, sel=2, in_valid=4'b1011 → no grant, out_valid drops to 0 after the pending word is accepted; then set sel=3 → ch3 granted next cycle.
- Assert reset_n=0 mid-transfer with out_valid=1 → out_valid=0, data_o=0, ch_o=0 immediately; after release with mode=1 and all channels valid, the first grant is channel 0.
- MUX_N_RR_CNT_EN defined: 5 transfers → xfer_cnt=5; cnt_clr pulsed with a transfer in the same cycle → xfer_cnt=0; with the counter preloaded by 65535 transfers, one more transfer → xfer_cnt wraps to 0.
